// File: rtl/jtkicker_psgctl_pkg.sv
// -----------------------------------------------------------------------------
// jtkicker_psgctl_pkg
// Shared definitions for the Kicker PSG write scheduler:
//   state_t  - scheduler FSM encoding (IDLE=0, SETUP=1, STROBE=2, WAIT=3)
//   entry_t  - one queued CPU write {sel, data}, ENTRY_W bits wide
// -----------------------------------------------------------------------------
package jtkicker_psgctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    localparam int ENTRY_W = 9;

    // sel: 0 = TI1, 1 = TI2
    typedef struct packed {
        logic       sel;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/jtkicker_psgctl_fifo.sv
// -----------------------------------------------------------------------------
// jtkicker_psgctl_fifo
// Small synchronous FIFO holding queued PSG writes.
// Ports:
//   clk, rstn     - system clock, asynchronous active-low reset
//   push, wdata   - write one entry (honoured when not full, or full with pop)
//   pop, rdata    - rdata shows the head entry; pop discards it
//   full, empty   - occupancy flags
//   count         - occupancy, 0 .. 2**AW
// -----------------------------------------------------------------------------
module jtkicker_psgctl_fifo
    import jtkicker_psgctl_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    output entry_t        rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // count tops out at exactly 2**AW, so its MSB alone means full
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at AW bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jtkicker_psgctl.sv
// -----------------------------------------------------------------------------
// jtkicker_psgctl
// Write scheduler between the 6809 bus and the two jt89 PSGs (TI1, TI2).
// CPU writes are queued and replayed to the addressed chip with a cs_n/wr_n
// strobe one target-cen period long, then the chip's ready is awaited.
// Ports:
//   clk, rstn             - 24 MHz clock, asynchronous active-low reset
//   cpu_cen, wr, sel, din - CPU write request (sel 0 = TI1, 1 = TI2)
//   full, busy            - queue full / scheduler has work pending
//   ovf, tout, clr_err    - sticky dropped-push / ready-timeout flags and clear
//   ti1_cen, ti2_cen      - PSG clock enables
//   psg_din               - shared PSG data bus
//   ti1_csn, ti2_csn      - per-chip chip selects (active low)
//   psg_wrn               - shared write strobe (active low)
//   ti1_rdy, ti2_rdy      - PSG ready handshakes
// -----------------------------------------------------------------------------
module jtkicker_psgctl
    import jtkicker_psgctl_pkg::*;
#(
    parameter int AW     = 2,
    parameter int TOUT_W = 6
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cpu_cen,
    input  logic       wr,
    input  logic       sel,
    input  logic [7:0] din,
    output logic       full,
    output logic       busy,
    output logic       ovf,
    output logic       tout,
    input  logic       clr_err,
    input  logic       ti1_cen,
    input  logic       ti2_cen,
    output logic [7:0] psg_din,
    output logic       ti1_csn,
    output logic       ti2_csn,
    output logic       psg_wrn,
    input  logic       ti1_rdy,
    input  logic       ti2_rdy
);

    // Timeout fires on the tick that would bring the count to 2**TOUT_W-1
    localparam logic [TOUT_W-1:0] TOUT_PRE = {TOUT_W{1'b1}} - 1'b1;

    state_t            state;
    state_t            state_nx;
    entry_t            cur;
    entry_t            fifo_q;
    entry_t            fifo_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic [TOUT_W-1:0] tcnt;
    logic              cen_t;
    logic              rdy_t;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              wait_tick;
    logic              tout_hit;
    logic              strobe_nx;

    assign fifo_d   = '{sel: sel, data: din};
    assign push_req = wr & cpu_cen;
    assign pop      = (state == ST_IDLE) & ~fifo_empty;
    assign push_ok  = push_req & (~fifo_full | pop);

    // cur.sel is stale while IDLE, but cen_t/rdy_t are only consulted after a pop
    assign cen_t     = cur.sel ? ti2_cen : ti1_cen;
    assign rdy_t     = cur.sel ? ti2_rdy : ti1_rdy;
    assign wait_tick = ((state == ST_SETUP) || (state == ST_WAIT)) & cen_t & ~rdy_t;
    assign tout_hit  = wait_tick & (tcnt == TOUT_PRE);

    assign full    = fifo_full;
    assign busy    = (fifo_count != '0) || (state != ST_IDLE);
    assign psg_din = cur.data;

    jtkicker_psgctl_fifo #(
        .AW (AW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_ok),
        .wdata (fifo_d),
        .pop   (pop),
        .rdata (fifo_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cen_t && rdy_t) begin
                    state_nx = ST_STROBE;
                end else if (tout_hit) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (cen_t) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if ((cen_t && rdy_t) || tout_hit) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they open and close
    // exactly on the target cen edge; only the latched chip's csn can drop
    assign strobe_nx = (state_nx == ST_STROBE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur     <= '0;
            ti1_csn <= 1'b1;
            ti2_csn <= 1'b1;
            psg_wrn <= 1'b1;
        end else begin
            if (pop) begin
                cur <= fifo_q;
            end
            ti1_csn <= ~(strobe_nx & ~cur.sel);
            ti2_csn <= ~(strobe_nx &  cur.sel);
            psg_wrn <= ~strobe_nx;
        end
    end

    // Not-ready ticks accumulate within one state; any state change restarts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt <= '0;
        end else if (state_nx != state) begin
            tcnt <= '0;
        end else if (wait_tick) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf  <= 1'b0;
            tout <= 1'b0;
        end else begin
            if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (tout_hit) begin
                tout <= 1'b1;
            end else if (clr_err) begin
                tout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtkicker_psgctl.sv
// -----------------------------------------------------------------------------
// tb_jtkicker_psgctl
// Directed bench for the PSG write scheduler. Both PSG cens tick every 4 clk
// (TI1 on phase 0, TI2 on phase 2). Each chip model holds ready low for 32 of
// its cens after it sees a completed write strobe; TI2 ready can be forced low.
// -----------------------------------------------------------------------------
module tb_jtkicker_psgctl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cpu_cen;
    logic       wr;
    logic       sel;
    logic [7:0] din;
    logic       full;
    logic       busy;
    logic       ovf;
    logic       tout;
    logic       clr_err;
    logic       ti1_cen;
    logic       ti2_cen;
    logic [7:0] psg_din;
    logic       ti1_csn;
    logic       ti2_csn;
    logic       psg_wrn;
    logic       ti1_rdy;
    logic       ti2_rdy;

    logic [1:0] cen_cnt = 2'd0;
    logic [5:0] busy1   = 6'd0;
    logic [5:0] busy2   = 6'd0;
    logic       hold2   = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    jtkicker_psgctl dut (
        .clk     (clk),
        .rstn    (rstn),
        .cpu_cen (cpu_cen),
        .wr      (wr),
        .sel     (sel),
        .din     (din),
        .full    (full),
        .busy    (busy),
        .ovf     (ovf),
        .tout    (tout),
        .clr_err (clr_err),
        .ti1_cen (ti1_cen),
        .ti2_cen (ti2_cen),
        .psg_din (psg_din),
        .ti1_csn (ti1_csn),
        .ti2_csn (ti2_csn),
        .psg_wrn (psg_wrn),
        .ti1_rdy (ti1_rdy),
        .ti2_rdy (ti2_rdy)
    );

    always #5 clk = ~clk;

    // PSG clock enables: one pulse every 4 clk per chip, phases offset
    always @(posedge clk) cen_cnt <= cen_cnt + 2'd1;
    assign ti1_cen = (cen_cnt == 2'd0);
    assign ti2_cen = (cen_cnt == 2'd2);

    // Chip ready models: a strobe still low on a cen tick is the latched write
    always @(posedge clk) begin
        if (ti1_cen && !ti1_csn && !psg_wrn) busy1 <= 6'd32;
        else if (ti1_cen && busy1 != 6'd0)   busy1 <= busy1 - 6'd1;
        if (ti2_cen && !ti2_csn && !psg_wrn) busy2 <= 6'd32;
        else if (ti2_cen && busy2 != 6'd0)   busy2 <= busy2 - 6'd1;
    end
    assign ti1_rdy = (busy1 == 6'd0);
    assign ti2_rdy = (busy2 == 6'd0) && !hold2;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; the push is sampled on the following posedge
    task automatic applyStimulus(input logic s, input logic [7:0] d);
        wr  = 1'b1;
        sel = s;
        din = d;
        @(negedge clk);
        wr  = 1'b0;
    endtask

    // Wait for the next strobe and check data, chip select and strobe length
    task automatic waitStrobe(input logic [7:0] exp_d, input logic exp_sel);
        int n = 0;
        int len = 0;
        logic unstable = 1'b0;
        while (ti1_csn && ti2_csn && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checkOutput("strobe_seen", 32'd0, 32'd1);
        end else begin
            checkOutput("strobe_data", psg_din, exp_d);
            checkOutput("strobe_ti1_csn", ti1_csn, exp_sel);
            checkOutput("strobe_ti2_csn", ti2_csn, !exp_sel);
            checkOutput("strobe_wrn", psg_wrn, 1'b0);
            while (!(ti1_csn && ti2_csn) && len < 100) begin
                if (psg_din !== exp_d || psg_wrn !== 1'b0) unstable = 1'b1;
                len++;
                @(negedge clk);
            end
            checkOutput("strobe_len", len, 32'd4);
            checkOutput("strobe_stable", unstable, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int cnt;
        logic strobed;

        rstn    = 1'b0;
        cpu_cen = 1'b1;
        wr      = 1'b0;
        sel     = 1'b0;
        din     = 8'h00;
        clr_err = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_full", full, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_ovf", ovf, 1'b0);
        checkOutput("rst_tout", tout, 1'b0);
        checkOutput("rst_psg_din", psg_din, 8'h00);
        checkOutput("rst_ti1_csn", ti1_csn, 1'b1);
        checkOutput("rst_ti2_csn", ti2_csn, 1'b1);
        checkOutput("rst_wrn", psg_wrn, 1'b1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // A write without cpu_cen is ignored
        cpu_cen = 1'b0;
        applyStimulus(1'b0, 8'hEE);
        cpu_cen = 1'b1;
        @(negedge clk);
        checkOutput("nocen_busy", busy, 1'b0);

        // 1: single write to TI1, busy drops on the 33rd cen after the strobe
        $display("[TB] single write");
        applyStimulus(1'b0, 8'h9F);
        waitStrobe(8'h9F, 1'b0);
        cnt = 0;
        while (busy && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("t1_busy_delay", cnt, 32'd132);
        checkOutput("t1_rdy_at_idle", ti1_rdy, 1'b1);

        // 2/3: fill the queue behind a TI2 write in progress, then overflow
        $display("[TB] back-to-back writes and overflow");
        applyStimulus(1'b1, 8'h11);
        @(negedge clk);
        applyStimulus(1'b0, 8'hAA);
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b0, 8'h0F);
        applyStimulus(1'b1, 8'hF0);
        checkOutput("t2_full", full, 1'b1);
        checkOutput("t2_ovf", ovf, 1'b0);
        applyStimulus(1'b0, 8'h77);
        checkOutput("t3_ovf_set", ovf, 1'b1);
        checkOutput("t3_full", full, 1'b1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checkOutput("t3_ovf_clr", ovf, 1'b0);

        // 6: push on exactly the cycle the head entry is popped
        n = 0;
        while (ti2_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_rdy_drop", ti2_rdy, 1'b0);
        n = 0;
        while (!(ti2_cen && ti2_rdy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_rdy_back", ti2_rdy, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h3C);
        checkOutput("t6_full", full, 1'b1);
        checkOutput("t6_ovf", ovf, 1'b0);
        checkOutput("t6_popped", psg_din, 8'hAA);

        waitStrobe(8'hAA, 1'b0);
        waitStrobe(8'h55, 1'b1);
        waitStrobe(8'h0F, 1'b0);
        waitStrobe(8'hF0, 1'b1);
        waitStrobe(8'h3C, 1'b0);
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t2_idle", busy, 1'b0);
        checkOutput("t2_empty_full", full, 1'b0);
        checkOutput("t2_ovf_end", ovf, 1'b0);

        // 4: TI2 never ready -> timeout after 63 ticks, next entry proceeds
        $display("[TB] ready timeout");
        hold2 = 1'b1;
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b0, 8'h5A);
        cnt = 0;
        n = 0;
        strobed = 1'b0;
        while (!tout && n < 1000) begin
            if (ti2_cen) cnt++;
            if (!ti2_csn) strobed = 1'b1;
            @(negedge clk);
            n++;
        end
        checkOutput("t4_tout", tout, 1'b1);
        checkOutput("t4_ticks", cnt, 32'd63);
        checkOutput("t4_no_strobe", strobed, 1'b0);
        checkOutput("t4_ti2_csn", ti2_csn, 1'b1);
        waitStrobe(8'h5A, 1'b0);
        hold2 = 1'b0;

        // 5: asynchronous reset in the middle of a strobe
        $display("[TB] reset during strobe");
        applyStimulus(1'b0, 8'hE7);
        applyStimulus(1'b0, 8'h12);
        n = 0;
        while (ti1_csn && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_strobe_low", ti1_csn, 1'b0);
        rstn = 1'b0;
        #1;
        checkOutput("t5_csn_rel", ti1_csn, 1'b1);
        checkOutput("t5_wrn_rel", psg_wrn, 1'b1);
        checkOutput("t5_busy_rst", busy, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_full", full, 1'b0);
        checkOutput("t5_tout", tout, 1'b0);
        checkOutput("t5_psg_din", psg_din, 8'h00);
        strobed = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (!ti1_csn || !ti2_csn) strobed = 1'b1;
        end
        checkOutput("t5_fifo_lost", strobed, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
